// File: rtl/wb_dbg_pkg.sv
// Shared definitions for the byte-stream driven Wishbone debug master:
// controller states, host command opcodes and response codes.
package wb_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

    // Command opcodes sent by the host ('W' and 'R')
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;

    // First response byte returned to the host
    localparam logic [7:0] RSP_OK     = 8'hA5;
    localparam logic [7:0] RSP_BERR   = 8'hE1;
    localparam logic [7:0] RSP_TOUT   = 8'hE2;
    localparam logic [7:0] RSP_BADCMD = 8'h3F;

    // True for the two opcodes that open a bus frame
    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WR) || (b == CMD_RD);
    endfunction

endpackage

// File: rtl/wb_dbg_bridge.sv
// Wishbone debug bridge: decodes host read/write frames from a byte stream,
// runs one pipelined 32-bit Wishbone cycle per frame and streams the status
// (plus read data) back to the host. One transaction in flight at a time.
module wb_dbg_bridge
    import wb_dbg_pkg::*;
#(
    parameter int BUS_TIMEOUT = 1024,
    parameter int RX_TIMEOUT  = 65535
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,

    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_stall_i
);

    localparam int BT_W = $clog2(BUS_TIMEOUT + 1);
    localparam int RT_W = $clog2(RX_TIMEOUT + 1);

    // Counter values seen on the last allowed cycle before giving up
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BUS_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(RX_TIMEOUT - 1);

    state_t          state;
    logic            is_write;
    logic [1:0]      byte_cnt;
    logic [RT_W-1:0] rx_timer;
    logic [BT_W-1:0] bus_timer;
    logic [31:0]     resp_sr;
    logic [2:0]      resp_left;
    logic            rx_take;

    // Only full-word transfers are issued
    assign wbm_sel_o = 4'hF;

    // A byte is consumed on the host handshake
    assign rx_take = rx_valid_i && rx_ready_o;

    // Frame decoder, bus sequencer and response serializer in one registered FSM
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            is_write   <= 1'b0;
            byte_cnt   <= 2'd0;
            rx_timer   <= '0;
            bus_timer  <= '0;
            resp_sr    <= 32'h0;
            resp_left  <= 3'd0;
            rx_ready_o <= 1'b0;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= 32'h0;
            wbm_dat_o  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rx_ready_o <= 1'b1;
                    if (rx_take) begin
                        if (is_cmd(rx_data_i)) begin
                            is_write <= (rx_data_i == CMD_WR);
                            byte_cnt <= 2'd0;
                            rx_timer <= '0;
                            state    <= ST_ADDR;
                        end else begin
                            // Unknown opcode: answer immediately, single byte
                            tx_data_o  <= RSP_BADCMD;
                            tx_valid_o <= 1'b1;
                            resp_left  <= 3'd0;
                            rx_ready_o <= 1'b0;
                            state      <= ST_RESP;
                        end
                    end
                end

                ST_ADDR: begin
                    if (rx_take) begin
                        wbm_adr_o <= {rx_data_i, wbm_adr_o[31:8]};
                        rx_timer  <= '0;
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (is_write) begin
                                state <= ST_DATA;
                            end else begin
                                // Read frame complete: cycle starts on the next clock
                                wbm_cyc_o  <= 1'b1;
                                wbm_stb_o  <= 1'b1;
                                wbm_we_o   <= 1'b0;
                                bus_timer  <= '0;
                                rx_ready_o <= 1'b0;
                                state      <= ST_BUS;
                            end
                        end
                    end else if (rx_timer == RT_LAST) begin
                        // Host went quiet mid-frame: drop it without answering
                        state <= ST_IDLE;
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (rx_take) begin
                        wbm_dat_o <= {rx_data_i, wbm_dat_o[31:8]};
                        rx_timer  <= '0;
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wbm_cyc_o  <= 1'b1;
                            wbm_stb_o  <= 1'b1;
                            wbm_we_o   <= 1'b1;
                            bus_timer  <= '0;
                            rx_ready_o <= 1'b0;
                            state      <= ST_BUS;
                        end
                    end else if (rx_timer == RT_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end

                ST_BUS: begin
                    bus_timer <= bus_timer + 1'b1;
                    if (wbm_stb_o && !wbm_stall_i) begin
                        wbm_stb_o <= 1'b0;
                    end
                    if (wbm_ack_i || wbm_err_i) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        wbm_we_o   <= 1'b0;
                        tx_valid_o <= 1'b1;
                        state      <= ST_RESP;
                        if (wbm_err_i) begin
                            // Error takes priority over a simultaneous ack
                            tx_data_o <= RSP_BERR;
                            resp_left <= 3'd0;
                        end else if (wbm_we_o) begin
                            tx_data_o <= RSP_OK;
                            resp_left <= 3'd0;
                        end else begin
                            tx_data_o <= RSP_OK;
                            resp_sr   <= wbm_dat_i;
                            resp_left <= 3'd4;
                        end
                    end else if (bus_timer == BT_LAST) begin
                        // Nobody answered (stalls included): abandon the cycle
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        wbm_we_o   <= 1'b0;
                        tx_data_o  <= RSP_TOUT;
                        tx_valid_o <= 1'b1;
                        resp_left  <= 3'd0;
                        state      <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (tx_valid_o && tx_ready_i) begin
                        if (resp_left == 3'd0) begin
                            tx_valid_o <= 1'b0;
                            rx_ready_o <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            // Read data goes out least significant byte first
                            tx_data_o <= resp_sr[7:0];
                            resp_sr   <= {8'h00, resp_sr[31:8]};
                            resp_left <= resp_left - 3'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_dbg_bridge.md
Name: wb_dbg_bridge

Overview:
- Wishbone master driven by a byte stream; the initiator counterpart to the SoC's Wishbone slaves (RAM, ROM, GPIO, UART, measure unit).
- Decodes read/write command frames from a host byte source (UART RX FIFO side) and issues single 32-bit pipelined-Wishbone cycles through a second master port of the crossbar.
- Returns status and read data as a byte stream to the host byte sink (UART TX FIFO side).
- Used for board bring-up and measure-unit calibration without CPU firmware.

Parameters:
- BUS_TIMEOUT, 1024, wb_clk_i cycles allowed from first stb to ack/err before the cycle is aborted.
- RX_TIMEOUT, 65535, idle wb_clk_i cycles allowed between bytes of one frame before the frame is discarded.

Ports:
- wb_clk_i  in  1  bus clock; single clock domain.
- wb_rst_i  in  1  reset, asynchronous assert, active-high.
- rx_data_i  in  8  incoming command byte.
- rx_valid_i  in  1  rx_data_i valid.
- rx_ready_o  out  1  byte accepted when rx_valid_i && rx_ready_o.
- tx_data_o  out  8  response byte.
- tx_valid_o  out  1  tx_data_o valid; held with stable data until tx_ready_i.
- tx_ready_i  in  1  sink accepts byte.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  always 4'hF.
- wbm_dat_i  in  32  read data.
- wbm_ack_i, wbm_err_i, wbm_stall_i  in  1 each  slave responses (pipelined mode).

Behaviour:
Reset (async, wb_rst_i=1):
- State=IDLE.
- cyc/stb/we=0, adr/dat=0, tx_valid_o=0, tx_data_o=0, rx_ready_o=0.
- Reset mid-bus-cycle drops cyc immediately; no response is sent.

Frames (multi-byte fields little-endian):
- Write: 0x57, A0..A3, D0..D3.
- Read: 0x52, A0..A3.
- Responses: write OK = 0xA5. Read OK = 0xA5, D0..D3. Bus error = 0xE1. Bus timeout = 0xE2. Unknown command = 0x3F.

States:
- IDLE: rx_ready_o=1.
  - 0x57/0x52 -> latch we, ADDR, byte counter=0.
  - Any other byte -> queue 0x3F, go RESP.
- ADDR: rx_ready_o=1; shift in 4 bytes. After the 4th: write -> DATA, read -> BUS.
- DATA: rx_ready_o=1; shift in 4 bytes -> BUS.
- BUS:
  - rx_ready_o=0.
  - Assert cyc=stb=1 on the cycle after entry.
  - stb deasserts on the first cycle with stb && !wbm_stall_i.
  - cyc holds until wbm_ack_i or wbm_err_i.
  - ack/err arriving in the same cycle stb is accepted is valid.
  - On ack: capture wbm_dat_i (read), queue 0xA5 (+4 data bytes if read).
  - On err: queue 0xE1. If ack and err are both set, err wins.
  - cyc drops the cycle after ack/err is seen (registered).
- Timeout: a counter starts at stb assertion. If it reaches BUS_TIMEOUT with no ack/err, drop cyc/stb, queue 0xE2, go RESP. Stall cycles count toward the timeout.
- RESP:
  - rx_ready_o=0.
  - Emit queued bytes in order. Advance on tx_valid_o && tx_ready_i.
  - After the last byte, tx_valid_o=0 next cycle, then IDLE.
  - Minimum one cycle per byte; tx_ready_i held high yields back-to-back bytes.
- RX timeout: in ADDR/DATA, a counter clears on each accepted byte. When it reaches RX_TIMEOUT, return to IDLE silently with no response and no bus cycle.

Issue latency:
- From acceptance of the last frame byte, cyc/stb assert exactly 1 cycle later.
- From ack, the first tx_valid_o assert is exactly 1 cycle later.

Other rules:
- Address is not checked or aligned; the crossbar decodes it.
- At most one outstanding transaction. No back-to-back frames overlap; input stalls via rx_ready_o=0 during BUS/RESP.

Decomposition:
- Package wb_dbg_pkg holds:
  - state enum (IDLE, ADDR, DATA, BUS, RESP)
  - command constants CMD_WR=8'h57, CMD_RD=8'h52
  - response constants RSP_OK=8'hA5, RSP_BERR=8'hE1, RSP_TOUT=8'hE2, RSP_BADCMD=8'h3F
- No sub-module required. The response serializer (5-byte shift register + count) stays inline.

Test Plan:
- Write frame 57 10 00 00 02 78 56 34 12, slave acks 1 cycle after stb -> adr=0x02000010, dat=0x12345678, we=1, sel=F, one stb cycle; response byte A5.
- Read frame 52 00 00 00 01, slave stalls 3 cycles then acks with 0xDEADBEEF -> stb held 4 cycles, exactly one accepted; response A5 EF BE AD DE.
- Read with no ack, BUS_TIMEOUT=16 -> cyc drops at cycle 16 after stb; response E2; a following read then completes normally.
- Write with wbm_err_i asserted together with ack -> response E1; cyc deasserted next cycle.
- Byte 0x00 in IDLE -> response 3F. Partial frame 52 00 then silence, RX_TIMEOUT=32 -> no bus cycle, no response; the next full frame is decoded correctly.
- tx_ready_i low 10 cycles during a read response -> tx_data_o stays stable at A5 until accepted. wb_rst_i pulse mid-BUS -> cyc=stb=tx_valid=0 asynchronously; IDLE after release.
